spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 109 ++++++++++
 tb/tb_spi_reg_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: bridges SCK-domain SPI slave address/data fields into a clk-domain register file
module spi_reg_bridge #(
   parameter int                DATA_W   = 24,
   parameter int                ADDR_W   = 7,
   parameter int                NREG     = 16,
   parameter logic [DATA_W-1:0] ID_VALUE = 24'hA50001
) (
   input  logic                         clk,
   input  logic                         spi_rst,
   input  logic [ADDR_W-1:0]            spi_addr,
   input  logic                         spi_addr_ready,
   input  logic                         spi_rw,
   input  logic [DATA_W-1:0]            spi_data,
   input  logic                         spi_data_ready,
   output logic [DATA_W-1:0]            spi_data_in,
   input  logic [15:0]                  status_in,
   output logic [(NREG-2)*DATA_W-1:0]   regs_o,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr
);
   typedef enum logic [2:0] {IDLE, ADDR, READ, WAIT_DATA, WRITE} state_t;
   state_t            r_st, w_nxt;
   logic [1:0]        r_ar_sync, r_dr_sync, r_live;
   logic              r_ar_dly, r_dr_dly, r_ar_arm, r_dr_arm;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rw, r_err;
   logic [DATA_W-1:0] r_regs [NREG-2];
   logic [DATA_W-1:0] w_rd;
   logic              w_ar_rise, w_dr_rise, w_rd_go, w_wr_go, w_wr_ok, w_err_clr;

   // synchronize ready levels; an edge is only armed once a genuine low level has been seen after reset
   always_ff @(posedge clk or posedge spi_rst)
      if (spi_rst) begin
         r_ar_sync <= '0;
         r_dr_sync <= '0;
         r_ar_dly  <= 1'b0;
         r_dr_dly  <= 1'b0;
         r_live    <= '0;
         r_ar_arm  <= 1'b0;
         r_dr_arm  <= 1'b0;
      end else begin
         r_ar_sync <= {r_ar_sync[0], spi_addr_ready};
         r_dr_sync <= {r_dr_sync[0], spi_data_ready};
         r_ar_dly  <= r_ar_sync[1];
         r_dr_dly  <= r_dr_sync[1];
         r_live    <= {r_live[0], 1'b1};
         r_ar_arm  <= r_ar_arm | (r_live[1] & ~r_ar_sync[1]);
         r_dr_arm  <= r_dr_arm | (r_live[1] & ~r_dr_sync[1]);
      end

   assign w_ar_rise = r_ar_sync[1] & ~r_ar_dly & r_ar_arm;
   assign w_dr_rise = r_dr_sync[1] & ~r_dr_dly & r_dr_arm;
   assign w_rd_go   = (r_st == ADDR) & r_rw & ~w_ar_rise;
   assign w_wr_go   = (r_st == WRITE) & ~w_ar_rise;
   assign w_wr_ok   = (r_addr >= ADDR_W'(2)) && (32'(r_addr) < NREG);
   assign w_err_clr = w_rd_go & (r_addr == ADDR_W'(1));

   // address map lookup for the latched address
   always_comb begin
      w_rd = '0;
      for (int k = 0; k < NREG-2; k++) if (r_addr == ADDR_W'(k+2)) w_rd = r_regs[k];
      if (r_addr == '0) w_rd = ID_VALUE;
      if (r_addr == ADDR_W'(1)) w_rd = DATA_W'({r_err, 7'b0, status_in});
   end

   // next state; a new address edge restarts the frame from any state
   always_comb begin
      w_nxt = r_st;
      case (r_st)
         ADDR:      w_nxt = r_rw ? READ : WAIT_DATA;
         READ:      w_nxt = WAIT_DATA;
         WAIT_DATA: w_nxt = w_dr_rise ? (r_rw ? IDLE : WRITE) : WAIT_DATA;
         WRITE:     w_nxt = IDLE;
         default:   w_nxt = IDLE;
      endcase
      if (w_ar_rise) w_nxt = ADDR;
   end

   // state register
   always_ff @(posedge clk or posedge spi_rst)
      if (spi_rst) r_st <= IDLE;
      else r_st <= w_nxt;

   // read data is registered on entry to READ so it is ready within 4 clk of the address edge
   always_ff @(posedge clk or posedge spi_rst)
      if (spi_rst) begin
         r_addr      <= '0;
         r_rw        <= 1'b0;
         r_err       <= 1'b0;
         spi_data_in <= '0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         for (int k = 0; k < NREG-2; k++) r_regs[k] <= '0;
      end else begin
         if (w_ar_rise) begin
            r_addr <= spi_addr;
            r_rw   <= spi_rw;
         end
         if (w_rd_go) spi_data_in <= w_rd;
         r_err     <= (w_wr_go & ~w_wr_ok) | (r_err & ~w_err_clr);
         wr_strobe <= w_wr_go & w_wr_ok;
         if (w_wr_go & w_wr_ok) wr_addr <= r_addr;
         for (int k = 0; k < NREG-2; k++) if (w_wr_go && r_addr == ADDR_W'(k+2)) r_regs[k] <= spi_data;
      end

   for (genvar g = 0; g < NREG-2; g++) begin : g_flat
      assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
   end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed and randomized SPI frames checked against an address-map model
module tb_spi_reg_bridge;
   localparam int DW = 24, AW = 7, NR = 16, VW = (NR-2)*DW;
   logic          clk = 0, spi_rst = 0;
   logic [AW-1:0] spi_addr = 0, wr_addr;
   logic          spi_addr_ready = 0, spi_rw = 0, spi_data_ready = 0, wr_strobe;
   logic [DW-1:0] spi_data = 0, spi_data_in;
   logic [15:0]   status_in = 0;
   logic [VW-1:0] regs_o;
   int            total = 0, bad = 0, n_stb = 0, e_stb = 0;
   logic [DW-1:0] m_regs [128];
   logic          m_err = 0;
   logic [AW-1:0] m_wa = 0;
   logic [DW-1:0] m_rd = 0;

   spi_reg_bridge dut (
      .clk(clk), .spi_rst(spi_rst), .spi_addr(spi_addr), .spi_addr_ready(spi_addr_ready),
      .spi_rw(spi_rw), .spi_data(spi_data), .spi_data_ready(spi_data_ready),
      .spi_data_in(spi_data_in), .status_in(status_in), .regs_o(regs_o),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe === 1'b1) n_stb++;

   function automatic logic [VW-1:0] m_vec();
      logic [VW-1:0] v;
      for (int k = 2; k < NR; k++) v[(k-2)*DW +: DW] = m_regs[k];
      return v;
   endfunction

   task automatic chk(input string t, input logic [VW-1:0] g, input logic [VW-1:0] e);
      total++;
      assert (g === e) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", t, g, e);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < 128; k++) m_regs[k] = 0;
      m_err = 0;
      m_wa = 0;
      m_rd = 0;
   endtask

   task automatic frame(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d, input bit abort);
      @(negedge clk);
      spi_addr = a;
      spi_rw = rw;
      spi_addr_ready = 1;
      repeat (4) @(posedge clk);
      #1;
      if (rw) begin
         m_rd = (a == 0) ? 24'hA50001 : (a == 1) ? {m_err, 7'b0, status_in} : (a < NR) ? m_regs[a] : 24'h0;
         if (a == 1) m_err = 0;
         chk("rd_latency", spi_data_in, m_rd);
      end
      if (!abort) begin
         repeat (20) @(negedge clk);
         spi_data = d;
         spi_data_ready = 1;
         repeat (8) @(negedge clk);
         if (!rw) begin
            if (a >= 2 && a < NR) begin
               m_regs[a] = d;
               e_stb++;
               m_wa = a;
            end else m_err = 1;
         end
         spi_data_ready = 0;
      end else repeat (8) @(negedge clk);
      spi_addr_ready = 0;
      spi_rw = 1'($urandom);
      spi_data = DW'($urandom);
      repeat (8) @(negedge clk);
      chk("strobes", n_stb, e_stb);
      chk("wr_addr", wr_addr, m_wa);
      chk("regs", regs_o, m_vec());
      chk("dout_hold", spi_data_in, m_rd);
   endtask

   initial begin
      logic [AW-1:0] a;
      int p;
      m_reset();
      #1 spi_rst = 1;
      #20;
      chk("rst_dout", spi_data_in, 0);
      chk("rst_regs", regs_o, 0);
      chk("rst_stb", wr_strobe, 0);
      chk("rst_waddr", wr_addr, 0);
      @(negedge clk) spi_rst = 0;
      repeat (5) @(negedge clk);

      frame(7'h05, 0, 24'h123456, 0);
      chk("w5_slice", regs_o[95:72], 24'h123456);
      frame(7'h01, 1, 0, 0);
      chk("err_clear0", spi_data_in, 24'h000000);

      frame(7'h00, 1, 0, 0);
      chk("id_read", spi_data_in, 24'hA50001);
      frame(7'h7F, 1, 0, 0);
      chk("hi_read", spi_data_in, 24'h000000);

      frame(7'h01, 0, 24'hFFFFFF, 0);
      status_in = 16'h00AA;
      frame(7'h01, 1, 0, 0);
      chk("err_set", spi_data_in, 24'h8000AA);
      frame(7'h01, 1, 0, 0);
      chk("err_cleared", spi_data_in, 24'h0000AA);

      frame(7'h03, 0, 24'hDEAD00, 1);
      frame(7'h04, 0, 24'h000001, 0);
      chk("abort_r3", regs_o[47:24], 24'h000000);
      chk("abort_r4", regs_o[71:48], 24'h000001);

      for (int k = 2; k < NR; k++) frame(AW'(k), 0, DW'($urandom), 0);
      for (int k = 2; k < NR; k++) frame(AW'(k), 1, 0, 0);

      for (int n = 0; n < 40; n++) begin
         p = $urandom_range(0, 19);
         a = (p == 19) ? 7'h7F : AW'(p);
         status_in = 16'($urandom);
         frame(a, 1'($urandom), DW'($urandom), $urandom_range(0, 5) == 0);
      end

      frame(7'h06, 0, 24'h777777, 0);
      @(negedge clk);
      spi_addr = 7'h06;
      spi_rw = 0;
      spi_addr_ready = 1;
      repeat (20) @(negedge clk);
      spi_data = 24'h5A5A5A;
      spi_data_ready = 1;
      repeat (3) @(posedge clk);
      #1 spi_rst = 1;
      #1;
      m_reset();
      chk("mid_rst_dout", spi_data_in, 0);
      chk("mid_rst_regs", regs_o, 0);
      chk("mid_rst_stb", wr_strobe, 0);
      chk("mid_rst_waddr", wr_addr, 0);
      repeat (3) @(negedge clk);
      spi_addr = 7'h05;
      spi_rst = 0;
      repeat (10) @(negedge clk);
      spi_data_ready = 0;
      repeat (8) @(negedge clk);
      spi_data_ready = 1;
      repeat (10) @(negedge clk);
      chk("held_stb", n_stb, e_stb);
      chk("held_regs", regs_o, 0);
      spi_data_ready = 0;
      spi_addr_ready = 0;
      repeat (8) @(negedge clk);

      frame(7'h0A, 0, 24'hC0FFEE, 0);
      frame(7'h0A, 1, 0, 0);
      chk("post_rst_rd", spi_data_in, 24'hC0FFEE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
